// File: rtl/mem_wb_stage_pkg.sv
// Shared widths, watchdog width and FSM state encoding for the memory /
// write-back stage.
package mem_wb_stage_pkg;

    localparam int REGISTER_LEN    = 32;
    localparam int REG_ADDRESS_LEN = 4;
    localparam int WDOG_WIDTH      = 8;

    typedef enum logic {
        MEM_WB_IDLE   = 1'b0,
        MEM_WB_ACCESS = 1'b1
    } mem_wb_state_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus. The stage is the master, the external
// memory (with arbitrary wait states) is the slave.
interface mem_wb_stage_if
    import mem_wb_stage_pkg::*;
();

    logic                    mem_req;
    logic                    mem_we;
    logic [REGISTER_LEN-1:0] mem_addr;
    logic [REGISTER_LEN-1:0] mem_wdata;
    logic [REGISTER_LEN-1:0] mem_rdata;
    logic                    mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_wb_stage_wb_register.sv
// Register-file write port register: loads a new data/address/enable triple
// every cycle (a bubble is simply en=0) and clears asynchronously.
module wb_register
    import mem_wb_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REGISTER_LEN-1:0]    data_d,
    input  logic [REG_ADDRESS_LEN-1:0] address_d,
    input  logic                       en_d,
    output logic [REGISTER_LEN-1:0]    data_q,
    output logic [REG_ADDRESS_LEN-1:0] address_q,
    output logic                       en_q
);

    // Unconditional load every edge; active-low reset clears the port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q    <= '0;
            address_q <= '0;
            en_q      <= 1'b0;
        end else begin
            data_q    <= data_d;
            address_q <= address_d;
            en_q      <= en_d;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: ALU results pass straight to the register
// file write port, loads and stores go through the req/ack memory bus while
// the upstream pipeline is stalled, and a watchdog aborts hung accesses.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       exe_wb_en,
    input  logic                       exe_mem_read,
    input  logic                       exe_mem_write,
    input  logic [REGISTER_LEN-1:0]    exe_alu_result,
    input  logic [REGISTER_LEN-1:0]    exe_store_value,
    input  logic [REG_ADDRESS_LEN-1:0] exe_dest,
    output logic                       stall,
    mem_wb_stage_if.master             mem,
    output logic [REGISTER_LEN-1:0]    reg_file_wb_data,
    output logic [REG_ADDRESS_LEN-1:0] reg_file_wb_address,
    output logic                       reg_file_wb_en,
    output logic                       mem_error
);

    // The abort fires on the MEM_TIMEOUT-th ACCESS cycle without an ack.
    localparam logic [WDOG_WIDTH-1:0] TIMEOUT_LAST = WDOG_WIDTH'(MEM_TIMEOUT - 1);
    localparam logic [WDOG_WIDTH-1:0] TIMEOUT_MAX  = WDOG_WIDTH'(MEM_TIMEOUT);

    mem_wb_state_t               state_q, state_d;
    logic [WDOG_WIDTH-1:0]       cnt_q, cnt_d;
    logic                        req_q, req_d;
    logic                        we_q, we_d;
    logic [REGISTER_LEN-1:0]     addr_q, addr_d;
    logic [REGISTER_LEN-1:0]     wdata_q, wdata_d;
    logic [REG_ADDRESS_LEN-1:0]  dest_q, dest_d;
    logic                        wb_en_cap_q, wb_en_cap_d;
    logic                        is_read_q, is_read_d;
    logic                        error_q, error_d;

    logic [REGISTER_LEN-1:0]     wb_data_d;
    logic [REG_ADDRESS_LEN-1:0]  wb_addr_d;
    logic                        wb_en_d;
    logic                        stall_int;

    // Next-state, captured-access and write-back selection; bubbles by default.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        dest_d      = dest_q;
        wb_en_cap_d = wb_en_cap_q;
        is_read_d   = is_read_q;
        error_d     = 1'b0;
        wb_data_d   = '0;
        wb_addr_d   = '0;
        wb_en_d     = 1'b0;
        stall_int   = 1'b0;

        case (state_q)
            MEM_WB_IDLE: begin
                if (exe_mem_read || exe_mem_write) begin
                    stall_int   = 1'b1;
                    state_d     = MEM_WB_ACCESS;
                    cnt_d       = '0;
                    req_d       = 1'b1;
                    we_d        = exe_mem_write;
                    addr_d      = exe_alu_result;
                    wdata_d     = exe_store_value;
                    dest_d      = exe_dest;
                    wb_en_cap_d = exe_wb_en;
                    is_read_d   = exe_mem_read;
                end else begin
                    wb_en_d   = exe_wb_en;
                    wb_data_d = exe_alu_result;
                    wb_addr_d = exe_dest;
                end
            end
            MEM_WB_ACCESS: begin
                if (mem.mem_ack) begin
                    state_d = MEM_WB_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (is_read_q) begin
                        wb_en_d   = wb_en_cap_q;
                        wb_data_d = mem.mem_rdata;
                        wb_addr_d = dest_q;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = MEM_WB_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    error_d = 1'b1;
                end else begin
                    stall_int = 1'b1;
                    cnt_d     = (cnt_q == TIMEOUT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: state_d = MEM_WB_IDLE;
        endcase
    end

    // State, watchdog and memory-bus registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= MEM_WB_IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            dest_q      <= '0;
            wb_en_cap_q <= 1'b0;
            is_read_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            dest_q      <= dest_d;
            wb_en_cap_q <= wb_en_cap_d;
            is_read_q   <= is_read_d;
            error_q     <= error_d;
        end
    end

    wb_register u_wb_register (
        .clk       (clk),
        .rst       (rst),
        .data_d    (wb_data_d),
        .address_d (wb_addr_d),
        .en_d      (wb_en_d),
        .data_q    (reg_file_wb_data),
        .address_q (reg_file_wb_address),
        .en_q      (reg_file_wb_en)
    );

    assign stall         = rst & stall_int;
    assign mem_error     = error_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: each instruction is run to completion against a
// memory responder with a chosen number of wait states, and the observed
// stall/req durations and write-back result are compared with a
// transaction-level model of the stage.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    localparam int T = 4;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic                       exe_wb_en = 1'b0;
    logic                       exe_mem_read = 1'b0;
    logic                       exe_mem_write = 1'b0;
    logic [REGISTER_LEN-1:0]    exe_alu_result = '0;
    logic [REGISTER_LEN-1:0]    exe_store_value = '0;
    logic [REG_ADDRESS_LEN-1:0] exe_dest = '0;
    logic                       stall;
    logic [REGISTER_LEN-1:0]    reg_file_wb_data;
    logic [REG_ADDRESS_LEN-1:0] reg_file_wb_address;
    logic                       reg_file_wb_en;
    logic                       mem_error;

    int errors = 0;
    int checks = 0;

    mem_wb_stage_if mem_if ();

    mem_wb_stage #(.MEM_TIMEOUT(T)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .exe_wb_en           (exe_wb_en),
        .exe_mem_read        (exe_mem_read),
        .exe_mem_write       (exe_mem_write),
        .exe_alu_result      (exe_alu_result),
        .exe_store_value     (exe_store_value),
        .exe_dest            (exe_dest),
        .stall               (stall),
        .mem                 (mem_if),
        .reg_file_wb_data    (reg_file_wb_data),
        .reg_file_wb_address (reg_file_wb_address),
        .reg_file_wb_en      (reg_file_wb_en),
        .mem_error           (mem_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stall_cycles;
        int          req_cycles;
        int          err_mid;
        logic        cap_req;
        logic        bus_we;
        logic [31:0] bus_addr;
        logic [31:0] bus_wdata;
        logic        bus_stable;
        logic        hung;
        logic        wb_en;
        logic [31:0] wb_data;
        logic [3:0]  wb_addr;
        logic        err;
        logic        req_after;
    } obs_t;

    typedef struct {
        int          stall_cycles;
        int          req_cycles;
        logic        wb_en;
        logic [31:0] wb_data;
        logic        err;
    } exp_t;

    // Instruction-level behaviour: waits < 0 means the memory never acks.
    function automatic exp_t model(input logic rd, input logic wr, input logic wbe,
                                   input logic [31:0] alu, input int waits,
                                   input logic [31:0] rdata);
        exp_t e;
        bit is_mem    = rd | wr;
        bit timed_out = is_mem && (waits < 0 || waits >= T);
        e.stall_cycles = !is_mem ? 0 : (timed_out ? T : 1 + waits);
        e.req_cycles   = !is_mem ? 0 : (timed_out ? T : 1 + waits);
        e.wb_en        = !is_mem ? wbe : ((rd && !timed_out) ? wbe : 1'b0);
        e.wb_data      = rd ? rdata : alu;
        e.err          = timed_out;
        return e;
    endfunction

    // Presents one instruction at a negedge and runs it until stall drops;
    // returns at the negedge after the completing edge.
    task automatic do_instr(input logic rd, input logic wr, input logic wbe,
                            input logic [31:0] alu, input logic [31:0] sv,
                            input logic [3:0] dest, input int waits,
                            input logic [31:0] rdata, output obs_t o);
        int cyc = 0;
        bit done = 0;
        o.stall_cycles = 0; o.req_cycles = 0; o.err_mid = 0; o.cap_req = 1'b0;
        o.bus_we = 1'b0; o.bus_addr = '0; o.bus_wdata = '0; o.bus_stable = 1'b1;
        exe_mem_read = rd; exe_mem_write = wr; exe_wb_en = wbe;
        exe_alu_result = alu; exe_store_value = sv; exe_dest = dest;
        while (!done && cyc < 300) begin
            if (mem_if.mem_req)
                mem_if.mem_ack = (waits >= 0 && o.req_cycles == waits);
            else
                mem_if.mem_ack = 1'($urandom_range(0, 1));
            mem_if.mem_rdata = mem_if.mem_ack ? rdata : $urandom;
            #1;
            if (cyc == 0) o.cap_req = mem_if.mem_req;
            if (stall) o.stall_cycles++;
            if (mem_if.mem_req) begin
                if (o.req_cycles == 0) begin
                    o.bus_we = mem_if.mem_we; o.bus_addr = mem_if.mem_addr;
                    o.bus_wdata = mem_if.mem_wdata;
                end else if (mem_if.mem_we !== o.bus_we || mem_if.mem_addr !== o.bus_addr ||
                             mem_if.mem_wdata !== o.bus_wdata) begin
                    o.bus_stable = 1'b0;
                end
                o.req_cycles++;
            end
            if (cyc > 0 && mem_error) o.err_mid++;
            done = !stall;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        mem_if.mem_ack = 1'b0;
        o.hung      = !done;
        o.wb_en     = reg_file_wb_en;
        o.wb_data   = reg_file_wb_data;
        o.wb_addr   = reg_file_wb_address;
        o.err       = mem_error;
        o.req_after = mem_if.mem_req;
    endtask

    task automatic test_reset();
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
        rst = 1'b0; exe_mem_read = 1'b1; exe_wb_en = 1'b1;
        #12;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (mem_if.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got=%b exp=0", mem_if.mem_req); end
        checks++; if (mem_if.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got=%b exp=0", mem_if.mem_we); end
        checks++; if (mem_if.mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got=%h exp=0", mem_if.mem_addr); end
        checks++; if (mem_if.mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata got=%h exp=0", mem_if.mem_wdata); end
        checks++; if (reg_file_wb_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_en got=%b exp=0", reg_file_wb_en); end
        checks++; if (reg_file_wb_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_wb_data got=%h exp=0", reg_file_wb_data); end
        checks++; if (reg_file_wb_address !== 4'h0) begin errors++; $display("[TB] FAIL reset_wb_addr got=%h exp=0", reg_file_wb_address); end
        checks++; if (mem_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error got=%b exp=0", mem_error); end
        exe_mem_read = 1'b0; exe_wb_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_alu();
        obs_t o;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            logic [31:0] alu  = (i == 0) ? 32'h0000_0011 : $urandom;
            logic [3:0]  dest = (i == 0) ? 4'd3 : 4'($urandom);
            logic        wbe  = (i == 0) ? 1'b1 : 1'($urandom);
            do_instr(1'b0, 1'b0, wbe, alu, $urandom, dest, 0, 32'h0, o);
            e = model(1'b0, 1'b0, wbe, alu, 0, 32'h0);
            checks++; if (o.stall_cycles != e.stall_cycles) begin errors++; $display("[TB] FAIL alu_stall got=%0d exp=%0d", o.stall_cycles, e.stall_cycles); end
            checks++; if (o.wb_en !== e.wb_en) begin errors++; $display("[TB] FAIL alu_wb_en got=%b exp=%b", o.wb_en, e.wb_en); end
            checks++; if (o.wb_data !== e.wb_data) begin errors++; $display("[TB] FAIL alu_wb_data got=%h exp=%h", o.wb_data, e.wb_data); end
            checks++; if (o.wb_addr !== dest) begin errors++; $display("[TB] FAIL alu_wb_addr got=%h exp=%h", o.wb_addr, dest); end
            checks++; if (o.req_cycles != 0) begin errors++; $display("[TB] FAIL alu_req got=%0d exp=0", o.req_cycles); end
        end
    endtask

    task automatic test_load_wait();
        obs_t o;
        exp_t e;
        do_instr(1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 4'd5, 3, 32'hDEAD_BEEF, o);
        e = model(1'b1, 1'b0, 1'b1, 32'h400, 3, 32'hDEAD_BEEF);
        checks++; if (o.hung) begin errors++; $display("[TB] FAIL load_hung got=1 exp=0"); end
        checks++; if (o.req_cycles != e.req_cycles) begin errors++; $display("[TB] FAIL load_req got=%0d exp=%0d", o.req_cycles, e.req_cycles); end
        checks++; if (o.stall_cycles != e.stall_cycles) begin errors++; $display("[TB] FAIL load_stall got=%0d exp=%0d", o.stall_cycles, e.stall_cycles); end
        checks++; if (o.bus_addr !== 32'h400 || o.bus_we !== 1'b0) begin errors++; $display("[TB] FAIL load_bus got=%h/%b exp=400/0", o.bus_addr, o.bus_we); end
        checks++; if (o.wb_en !== e.wb_en || o.wb_data !== e.wb_data) begin errors++; $display("[TB] FAIL load_wb got=%b/%h exp=%b/%h", o.wb_en, o.wb_data, e.wb_en, e.wb_data); end
        checks++; if (o.wb_addr !== 4'd5) begin errors++; $display("[TB] FAIL load_wb_addr got=%h exp=5", o.wb_addr); end
        checks++; if (o.req_after !== 1'b0) begin errors++; $display("[TB] FAIL load_req_drop got=%b exp=0", o.req_after); end
    endtask

    task automatic test_store_immediate();
        obs_t o;
        exp_t e;
        do_instr(1'b0, 1'b1, 1'b1, 32'h100, 32'h5, 4'd7, 0, 32'h0, o);
        e = model(1'b0, 1'b1, 1'b1, 32'h100, 0, 32'h0);
        checks++; if (o.req_cycles != e.req_cycles) begin errors++; $display("[TB] FAIL store_req got=%0d exp=%0d", o.req_cycles, e.req_cycles); end
        checks++; if (o.bus_we !== 1'b1 || o.bus_wdata !== 32'h5 || o.bus_addr !== 32'h100) begin errors++; $display("[TB] FAIL store_bus got=%b/%h/%h exp=1/5/100", o.bus_we, o.bus_wdata, o.bus_addr); end
        checks++; if (o.wb_en !== e.wb_en) begin errors++; $display("[TB] FAIL store_wb_en got=%b exp=%b", o.wb_en, e.wb_en); end
        checks++; if (o.stall_cycles != e.stall_cycles) begin errors++; $display("[TB] FAIL store_stall got=%0d exp=%0d", o.stall_cycles, e.stall_cycles); end
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        do_instr(1'b1, 1'b0, 1'b1, 32'h800, 32'h0, 4'd9, -1, 32'h0, o);
        e = model(1'b1, 1'b0, 1'b1, 32'h800, -1, 32'h0);
        checks++; if (o.hung) begin errors++; $display("[TB] FAIL timeout_hung got=1 exp=0"); end
        checks++; if (o.req_cycles != e.req_cycles) begin errors++; $display("[TB] FAIL timeout_req got=%0d exp=%0d", o.req_cycles, e.req_cycles); end
        checks++; if (o.stall_cycles != e.stall_cycles) begin errors++; $display("[TB] FAIL timeout_stall got=%0d exp=%0d", o.stall_cycles, e.stall_cycles); end
        checks++; if (o.err !== e.err || o.err_mid != 0) begin errors++; $display("[TB] FAIL timeout_error got=%b/%0d exp=%b/0", o.err, o.err_mid, e.err); end
        checks++; if (o.wb_en !== 1'b0 || o.req_after !== 1'b0) begin errors++; $display("[TB] FAIL timeout_bubble got=%b/%b exp=0/0", o.wb_en, o.req_after); end
        do_instr(1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 4'd2, 0, 32'h0, o);
        checks++; if (o.err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_pulse_width got=%b exp=0", o.err); end
        checks++; if (o.wb_en !== 1'b1 || o.wb_data !== 32'h1234 || o.wb_addr !== 4'd2) begin errors++; $display("[TB] FAIL timeout_next_alu got=%b/%h/%h exp=1/1234/2", o.wb_en, o.wb_data, o.wb_addr); end
        do_instr(1'b1, 1'b0, 1'b1, 32'h900, 32'h0, 4'd4, T - 1, 32'hCAFE_0001, o);
        e = model(1'b1, 1'b0, 1'b1, 32'h900, T - 1, 32'hCAFE_0001);
        checks++; if (o.err !== e.err || o.wb_en !== e.wb_en || o.wb_data !== e.wb_data) begin errors++; $display("[TB] FAIL ack_on_timeout got=%b/%b/%h exp=%b/%b/%h", o.err, o.wb_en, o.wb_data, e.err, e.wb_en, e.wb_data); end
        checks++; if (o.stall_cycles != e.stall_cycles) begin errors++; $display("[TB] FAIL ack_on_timeout_stall got=%0d exp=%0d", o.stall_cycles, e.stall_cycles); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            logic        rd    = (i != 1);
            logic [31:0] alu   = $urandom;
            logic [31:0] rdata = $urandom;
            do_instr(rd, ~rd, 1'b1, alu, $urandom, 4'(i + 1), (i == 0) ? 1 : (i == 1) ? 2 : 0, rdata, o);
            e = model(rd, ~rd, 1'b1, alu, (i == 0) ? 1 : (i == 1) ? 2 : 0, rdata);
            checks++; if (o.cap_req !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap got=%b exp=0", o.cap_req); end
            checks++; if (o.req_cycles != e.req_cycles) begin errors++; $display("[TB] FAIL b2b_req got=%0d exp=%0d", o.req_cycles, e.req_cycles); end
            checks++; if (o.wb_en !== e.wb_en || (e.wb_en && o.wb_data !== e.wb_data)) begin errors++; $display("[TB] FAIL b2b_wb got=%b/%h exp=%b/%h", o.wb_en, o.wb_data, e.wb_en, e.wb_data); end
        end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            int          kind  = $urandom_range(0, 2);
            logic        rd    = (kind == 1);
            logic        wr    = (kind == 2);
            logic        wbe   = 1'($urandom);
            logic [31:0] alu   = $urandom;
            logic [31:0] sv    = $urandom;
            logic [31:0] rdata = $urandom;
            logic [3:0]  dest  = 4'($urandom);
            int          waits = $urandom_range(0, 5);
            do_instr(rd, wr, wbe, alu, sv, dest, waits, rdata, o);
            e = model(rd, wr, wbe, alu, waits, rdata);
            checks++; if (o.hung) begin errors++; $display("[TB] FAIL rnd_hung i=%0d", i); end
            checks++; if (o.stall_cycles != e.stall_cycles) begin errors++; $display("[TB] FAIL rnd_stall i=%0d got=%0d exp=%0d", i, o.stall_cycles, e.stall_cycles); end
            checks++; if (o.req_cycles != e.req_cycles) begin errors++; $display("[TB] FAIL rnd_req i=%0d got=%0d exp=%0d", i, o.req_cycles, e.req_cycles); end
            checks++; if (o.wb_en !== e.wb_en) begin errors++; $display("[TB] FAIL rnd_wb_en i=%0d got=%b exp=%b", i, o.wb_en, e.wb_en); end
            if (e.wb_en) begin
                checks++; if (o.wb_data !== e.wb_data || o.wb_addr !== dest) begin errors++; $display("[TB] FAIL rnd_wb i=%0d got=%h/%h exp=%h/%h", i, o.wb_data, o.wb_addr, e.wb_data, dest); end
            end
            checks++; if (o.err !== e.err || o.err_mid != 0) begin errors++; $display("[TB] FAIL rnd_error i=%0d got=%b/%0d exp=%b/0", i, o.err, o.err_mid, e.err); end
            if (rd || wr) begin
                checks++; if (o.cap_req !== 1'b0 || o.bus_stable !== 1'b1) begin errors++; $display("[TB] FAIL rnd_bus_hold i=%0d got=%b/%b exp=0/1", i, o.cap_req, o.bus_stable); end
                checks++; if (o.bus_addr !== alu || o.bus_we !== wr || (wr && o.bus_wdata !== sv)) begin errors++; $display("[TB] FAIL rnd_bus i=%0d got=%h/%b/%h exp=%h/%b/%h", i, o.bus_addr, o.bus_we, o.bus_wdata, alu, wr, sv); end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        obs_t o;
        exe_mem_read = 1'b1; exe_mem_write = 1'b0; exe_wb_en = 1'b1;
        exe_alu_result = 32'hA0; exe_dest = 4'd6; mem_if.mem_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        checks++; if (mem_if.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_pre_req got=%b exp=1", mem_if.mem_req); end
        #2 rst = 1'b0;
        #1;
        checks++; if (mem_if.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_req got=%b exp=0", mem_if.mem_req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stall got=%b exp=0", stall); end
        checks++; if (reg_file_wb_en !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_wb_en got=%b exp=0", reg_file_wb_en); end
        exe_mem_read = 1'b0; exe_wb_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); @(negedge clk);
        checks++; if (mem_if.mem_req !== 1'b0 || reg_file_wb_en !== 1'b0 || mem_error !== 1'b0) begin errors++; $display("[TB] FAIL late_ack got=%b/%b/%b exp=0/0/0", mem_if.mem_req, reg_file_wb_en, mem_error); end
        mem_if.mem_ack = 1'b0;
        do_instr(1'b0, 1'b0, 1'b1, 32'h77, 32'h0, 4'd8, 0, 32'h0, o);
        checks++; if (o.wb_en !== 1'b1 || o.wb_data !== 32'h77 || o.wb_addr !== 4'd8) begin errors++; $display("[TB] FAIL rstmid_next_alu got=%b/%h/%h exp=1/77/8", o.wb_en, o.wb_data, o.wb_addr); end
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_store_immediate();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and write-back stage of the ARM pipeline, and the producer of the register-file write port that the decode stage consumes (`reg_file_wb_data`, `reg_file_wb_address`, `reg_file_wb_en`). It takes the execute-stage result and control bits, performs loads and stores through a req/ack handshake to an external data memory with arbitrary wait states, and stalls the upstream pipeline while an access is outstanding. A watchdog aborts accesses that never complete. Write-back is registered, so each result reaches the register file one edge after it is final.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: ACCESS cycles without ack before an abort (1..255).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `exe_wb_en`  in  1  instruction writes a register.
- `exe_mem_read`  in  1  load.
- `exe_mem_write`  in  1  store; `exe_mem_read` and `exe_mem_write` are never both 1.
- `exe_alu_result`  in  `REGISTER_LEN`  ALU result, also the memory address.
- `exe_store_value`  in  `REGISTER_LEN`  store data.
- `exe_dest`  in  `REG_ADDRESS_LEN`  destination register.
- `stall`  out  1  upstream holds all `exe_*` inputs stable while 1 (combinational).
- `mem_req`, `mem_we`  out  1  access request / write strobe (registered).
- `mem_addr`, `mem_wdata`  out  `REGISTER_LEN`  address / store data (registered).
- `mem_rdata`  in  `REGISTER_LEN`  load data, valid when `mem_ack`=1.
- `mem_ack`  in  1  access complete.
- `reg_file_wb_data`  out  `REGISTER_LEN`.
- `reg_file_wb_address`  out  `REG_ADDRESS_LEN`.
- `reg_file_wb_en`  out  1.
- `mem_error`  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, ACCESS.
- IDLE, no memory op: at the next edge, `reg_file_wb_en`<=`exe_wb_en`, `reg_file_wb_data`<=`exe_alu_result`, `reg_file_wb_address`<=`exe_dest`. `stall`=0.
- IDLE, memory op: `stall`=1. At the next edge, capture the address, store data, dest, `wb_en` and the read/write flag. Drive `mem_req`=1 and `mem_we`=`exe_mem_write`, go to ACCESS, and clear the watchdog counter. Write-back register loads a bubble (`reg_file_wb_en`=0).
- ACCESS: `mem_req` stays 1 with `mem_addr`, `mem_wdata` and `mem_we` constant. `stall`=~`mem_ack`.
  - On an edge with `mem_ack`=1: drop `mem_req`/`mem_we` and return to IDLE.
  - For a load, `reg_file_wb_data`<=`mem_rdata`, `reg_file_wb_en`<=captured `wb_en`, address<=captured dest.
  - For a store, `reg_file_wb_en`<=0.
  - Otherwise, write-back loads a bubble and the counter increments.
- Timeout: counter reaches `MEM_TIMEOUT` with no ack. Force `stall`=0 that cycle. At the edge: IDLE, `mem_req`=0, `mem_error`=1 for one cycle, write-back bubble, instruction dropped.
- `mem_ack` in IDLE is ignored.
- Ack arriving on the timeout cycle wins: normal completion, no `mem_error`.

## Timing
- Reset (async assert): state IDLE, and every output register 0. This covers `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `reg_file_wb_*` and `mem_error`. Reset mid-ACCESS drops `mem_req` immediately, with no write-back. `stall` is 0 in reset.
- ALU-only latency: result visible on `reg_file_wb_*` 1 edge after presentation.
- Load latency: 2 edges after presentation with ack in the first ACCESS cycle, +1 per wait state. `stall` is high for 1 + wait-state cycles.
- Back-to-back memory ops: after completion, one IDLE cycle precedes the next `mem_req` (capture cycle).
- Counter width 8 bits, no wrap: it stops at `MEM_TIMEOUT`.

## Structure
- `REGISTER_LEN`, `REG_ADDRESS_LEN` and state encodings (`MEM_WB_IDLE`=0, `MEM_WB_ACCESS`=1) go in `Defines.v`.
- One natural sub-module: `wb_register`, the enable-less write-back register triple (`data`/`address`/`en`) with async active-low clear.

## Test plan
- ALU op: `exe_wb_en`=1, `exe_alu_result`=32'h0000_0011, `exe_dest`=4'd3 -> next edge `reg_file_wb_en`=1, data 32'h11, addr 3, `stall` never 1.
- Load, 3 wait states: `exe_mem_read`=1, addr 32'h400, `mem_rdata`=32'hDEAD_BEEF on ack -> `mem_req` high 4 cycles, `stall` high 4 cycles, then `reg_file_wb_data`=32'hDEAD_BEEF, `reg_file_wb_en`=1 one edge after ack.
- Store with immediate ack: `exe_store_value`=32'h5 -> `mem_we`=1, `mem_wdata`=32'h5 for 1 cycle, `reg_file_wb_en` stays 0.
- Timeout with `MEM_TIMEOUT`=4 and no ack -> `mem_req` high 4 cycles, `mem_error` pulses once, returns to IDLE, next ALU op writes back normally.
- Reset asserted mid-ACCESS -> `mem_req`, `stall` and `reg_file_wb_en` go 0 asynchronously. A late `mem_ack` after release is ignored.
- Spurious `mem_ack`=1 in IDLE during ALU ops -> no effect on outputs.
